// File: rtl/mips_lsu_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mips_lsu_pkg : shared encodings for the MIPS load/store unit      |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package mips_lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_ILL  = 2'd3
    } size_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_MERGE = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;

    // Big-endian lanes: lane 0 is the most significant byte/half.
    localparam logic [1:0] LANE_B0 = 2'd0;
    localparam logic [1:0] LANE_B1 = 2'd1;
    localparam logic [1:0] LANE_B2 = 2'd2;
    localparam logic       HALF_HI = 1'b0;

    function automatic logic is_misaligned(input size_e sz, input logic [1:0] lo);
        case (sz)
            SZ_HALF: return lo[0];
            SZ_WORD: return |lo;
            default: return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mips_lsu_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mips_lsu_if / mips_dmem_if : pipeline request bus and data-memory |
// | port of the load/store unit.  Rev 1.0                             |
// +------------------------------------------------------------------+
interface mips_lsu_if #(
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [DATA_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

interface mips_dmem_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] address;
    logic [DATA_W-1:0] write_data;
    logic              mem_to_reg;
    logic [DATA_W-1:0] read_data;

    modport master (
        output address, write_data, mem_to_reg,
        input  read_data
    );

    modport slave (
        input  address, write_data, mem_to_reg,
        output read_data
    );
endinterface
`default_nettype wire

// File: rtl/mips_lsu_lane.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mips_lsu_lane : combinational big-endian lane extract/extend and  |
// | sub-word store merge.  Rev 1.0                                    |
// +------------------------------------------------------------------+
module mips_lsu_lane
    import mips_lsu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  wire logic [DATA_W-1:0] word,
    input  wire logic [1:0]        addr_lo,
    input  var  size_e             size,
    input  wire logic              is_unsigned,
    input  wire logic [DATA_W-1:0] wdata,
    output logic      [DATA_W-1:0] load_data,
    output logic      [DATA_W-1:0] merged
);

    logic [BYTE_W-1:0] w_byte;
    logic [HALF_W-1:0] w_half;
    logic              w_sign;

    always_comb begin
        w_byte    = word[7:0];
        w_half    = word[15:0];
        w_sign    = 1'b0;
        load_data = word;
        merged    = word;

        case (addr_lo)
            LANE_B0: w_byte = word[31:24];
            LANE_B1: w_byte = word[23:16];
            LANE_B2: w_byte = word[15:8];
            default: w_byte = word[7:0];
        endcase

        if (addr_lo[1] == HALF_HI) begin
            w_half = word[31:16];
        end

        case (size)
            SZ_BYTE: begin
                w_sign    = ~is_unsigned & w_byte[BYTE_W-1];
                load_data = {{(DATA_W-BYTE_W){w_sign}}, w_byte};
                case (addr_lo)
                    LANE_B0: merged[31:24] = wdata[7:0];
                    LANE_B1: merged[23:16] = wdata[7:0];
                    LANE_B2: merged[15:8]  = wdata[7:0];
                    default: merged[7:0]   = wdata[7:0];
                endcase
            end
            SZ_HALF: begin
                w_sign    = ~is_unsigned & w_half[HALF_W-1];
                load_data = {{(DATA_W-HALF_W){w_sign}}, w_half};
                if (addr_lo[1] == HALF_HI) begin
                    merged[31:16] = wdata[15:0];
                end else begin
                    merged[15:0] = wdata[15:0];
                end
            end
            default: begin
                load_data = word;
                merged    = wdata;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mips_lsu.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mips_lsu : MIPS load/store unit, word-wide sync data-memory master|
// | Optional: LSU_ALIGN_CHECK_EN rejects misaligned half/word access. |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module mips_lsu
    import mips_lsu_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int MEM_IDX_W = 8
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    mips_lsu_if.slave   lsu,
    mips_dmem_if.master mem
);

    state_e            r_state;
    state_e            w_next;
    logic              r_we;
    size_e             r_size;
    logic              r_unsigned;
    logic [DATA_W-1:0] r_addr;
    logic [DATA_W-1:0] r_write_data;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;

    size_e             w_req_size;
    logic [DATA_W-1:0] w_req_addr;
    logic              w_accept;
    logic              w_reject;
    logic [DATA_W-1:0] w_load;
    logic [DATA_W-1:0] w_merged;

    assign w_req_size = size_e'(lsu.req_size);
    assign w_accept   = lsu.req_valid && (r_state == ST_IDLE);

`ifdef LSU_ALIGN_CHECK_EN
    assign w_reject   = (w_req_size == SZ_ILL) ||
                        is_misaligned(w_req_size, lsu.req_addr[1:0]);
    assign w_req_addr = lsu.req_addr;
`else
    assign w_reject = (w_req_size == SZ_ILL);

    // Misalignment is tolerated by snapping to the natural boundary.
    always_comb begin
        w_req_addr = lsu.req_addr;
        if (w_req_size == SZ_HALF) begin
            w_req_addr[0] = 1'b0;
        end else if (w_req_size == SZ_WORD) begin
            w_req_addr[1:0] = 2'b00;
        end
    end
`endif

    mips_lsu_lane #(
        .DATA_W (DATA_W)
    ) u_lane (
        .word        (mem.read_data),
        .addr_lo     (r_addr[1:0]),
        .size        (r_size),
        .is_unsigned (r_unsigned),
        .wdata       (r_write_data),
        .load_data   (w_load),
        .merged      (w_merged)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_reject) begin
                        w_next = ST_DONE;
                    end else if (lsu.req_we && (w_req_size == SZ_WORD)) begin
                        w_next = ST_WRITE;
                    end else begin
                        w_next = ST_READ;
                    end
                end
            end
            ST_READ:  w_next = ST_MERGE;
            ST_MERGE: w_next = r_we ? ST_WRITE : ST_DONE;
            ST_WRITE: w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // The write_data register doubles as the store-data holding register
    // until MERGE overwrites it with the read-modify-write result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we         <= 1'b0;
            r_size       <= SZ_BYTE;
            r_unsigned   <= 1'b0;
            r_addr       <= '0;
            r_write_data <= '0;
            r_rdata      <= '0;
            r_err        <= 1'b0;
        end else if (w_accept) begin
            r_we       <= lsu.req_we;
            r_size     <= w_req_size;
            r_unsigned <= lsu.req_unsigned;
            r_addr     <= w_req_addr;
            r_rdata    <= '0;
            r_err      <= w_reject;
            if (lsu.req_we) begin
                r_write_data <= lsu.req_wdata;
            end
        end else if (r_state == ST_MERGE) begin
            if (r_we) begin
                r_write_data <= w_merged;
            end else begin
                r_rdata <= w_load;
            end
        end
    end

    assign lsu.req_ready  = (r_state == ST_IDLE);
    assign lsu.resp_valid = (r_state == ST_DONE);
    assign lsu.resp_rdata = r_rdata;
    assign lsu.resp_err   = r_err;

    // Upper address bits pass through untouched beside the memory index field.
    assign mem.address    = {2'b00, r_addr[DATA_W-1:MEM_IDX_W+2], r_addr[MEM_IDX_W+1:2]};
    assign mem.write_data = r_write_data;
    assign mem.mem_to_reg = (r_state != ST_WRITE);

endmodule
`default_nettype wire

// File: tb/tb_mips_lsu.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_mips_lsu : directed self-checking bench for mips_lsu with a    |
// | behavioural 256-word synchronous data memory.  Rev 1.0            |
// +------------------------------------------------------------------+
module tb_mips_lsu;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    logic [31:0] mem_arr [256];
    logic        bd_we;
    logic [7:0]  bd_idx;
    logic [31:0] bd_data;

    mips_lsu_if  lsu_bus ();
    mips_dmem_if mem_bus ();

    mips_lsu #(
        .DATA_W    (32),
        .MEM_IDX_W (8)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .lsu   (lsu_bus),
        .mem   (mem_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bd_we) begin
            mem_arr[bd_idx] <= bd_data;
        end else if (!mem_bus.mem_to_reg) begin
            mem_arr[mem_bus.address[7:0]] <= mem_bus.write_data;
        end
        mem_bus.read_data <= mem_arr[mem_bus.address[7:0]];
    end

    function automatic logic [31:0] init_val(input int i);
        return 32'hA500_0000 | 32'(i);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bd_write(input logic [7:0] idx, input logic [31:0] data);
        @(negedge clk);
        bd_we   = 1'b1;
        bd_idx  = idx;
        bd_data = data;
        @(negedge clk);
        bd_we   = 1'b0;
    endtask

    task automatic drive_req(input logic we, input logic [1:0] sz, input logic uns,
                             input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        lsu_bus.req_valid    = 1'b1;
        lsu_bus.req_we       = we;
        lsu_bus.req_size     = sz;
        lsu_bus.req_unsigned = uns;
        lsu_bus.req_addr     = a;
        lsu_bus.req_wdata    = wd;
        @(posedge clk);
        @(negedge clk);
        lsu_bus.req_valid    = 1'b0;
    endtask

    // Latency k means resp_valid was seen in cycle T+k after the accepting edge T.
    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd,
                          output int lat, output logic [31:0] rd, output logic err,
                          output int wr_cnt, output logic [31:0] wr_addr);
        lat = 0; rd = '0; err = 1'b0; wr_cnt = 0; wr_addr = '0;
        drive_req(we, sz, uns, a, wd);
        for (int k = 1; k <= 10; k++) begin
            if (k > 1) @(negedge clk);
            if (!mem_bus.mem_to_reg) begin
                wr_cnt++;
                wr_addr = mem_bus.address;
            end
            if (lsu_bus.resp_valid) begin
                lat = k;
                rd  = lsu_bus.resp_rdata;
                err = lsu_bus.resp_err;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          lat;
        int          wrc;
        int          cnt;
        logic [31:0] rd;
        logic [31:0] wa;
        logic        err;
        logic        found;

        tests = 0;
        fails = 0;
        bd_we = 1'b0; bd_idx = '0; bd_data = '0;
        lsu_bus.req_valid = 1'b0; lsu_bus.req_we = 1'b0; lsu_bus.req_size = 2'd0;
        lsu_bus.req_unsigned = 1'b0; lsu_bus.req_addr = '0; lsu_bus.req_wdata = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;

        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            bd_we = 1'b1; bd_idx = 8'(i); bd_data = init_val(i);
        end
        @(negedge clk);
        bd_we = 1'b0;

        chk("rst_mem_to_reg", 32'(mem_bus.mem_to_reg), 32'd1);
        chk("rst_req_ready",  32'(lsu_bus.req_ready),  32'd1);
        chk("rst_resp_valid", 32'(lsu_bus.resp_valid), 32'd0);
        chk("rst_resp_err",   32'(lsu_bus.resp_err),   32'd0);
        chk("rst_resp_rdata", lsu_bus.resp_rdata,      32'd0);
        chk("rst_address",    mem_bus.address,         32'd0);
        chk("rst_write_data", mem_bus.write_data,      32'd0);

        @(negedge clk) rst_n = 1'b1;
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (!mem_bus.mem_to_reg || lsu_bus.resp_valid) cnt++;
        end
        chk("idle_no_activity", 32'(cnt), 32'd0);
        cnt = 0;
        for (int i = 0; i < 256; i++) if (mem_arr[i] !== init_val(i)) cnt++;
        chk("idle_mem_unchanged", 32'(cnt), 32'd0);

        do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, lat, rd, err, wrc, wa);
        chk("sw_lat",     32'(lat), 32'd2);
        chk("sw_wr_cnt",  32'(wrc), 32'd1);
        chk("sw_wr_addr", wa,       32'd4);
        chk("sw_err",     32'(err), 32'd0);
        chk("sw_mem4",    mem_arr[4], 32'hDEAD_BEEF);

        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, lat, rd, err, wrc, wa);
        chk("lw_lat",    32'(lat), 32'd3);
        chk("lw_rdata",  rd,       32'hDEAD_BEEF);
        chk("lw_wr_cnt", 32'(wrc), 32'd0);

        bd_write(8'd4, 32'h1122_3344);
        do_req(1'b1, 2'd0, 1'b0, 32'h12, 32'h1234_56AA, lat, rd, err, wrc, wa);
        chk("sb_lat",    32'(lat), 32'd4);
        chk("sb_wr_cnt", 32'(wrc), 32'd1);
        chk("sb_mem4",   mem_arr[4], 32'h1122_AA44);
        chk("sb_rdata",  rd,       32'd0);

        do_req(1'b0, 2'd0, 1'b0, 32'h12, 32'h0, lat, rd, err, wrc, wa);
        chk("lb_12",     rd,       32'hFFFF_FFAA);
        chk("lb_12_lat", 32'(lat), 32'd3);
        do_req(1'b0, 2'd0, 1'b1, 32'h12, 32'h0, lat, rd, err, wrc, wa);
        chk("lbu_12", rd, 32'h0000_00AA);
        do_req(1'b0, 2'd0, 1'b0, 32'h10, 32'h0, lat, rd, err, wrc, wa);
        chk("lb_10", rd, 32'h0000_0011);
        do_req(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, lat, rd, err, wrc, wa);
        chk("lb_13", rd, 32'h0000_0044);
        do_req(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, lat, rd, err, wrc, wa);
        chk("lh_12", rd, 32'hFFFF_AA44);
        do_req(1'b0, 2'd1, 1'b1, 32'h10, 32'h0, lat, rd, err, wrc, wa);
        chk("lhu_10", rd, 32'h0000_1122);

        do_req(1'b1, 2'd1, 1'b0, 32'h16, 32'hFFFF_8001, lat, rd, err, wrc, wa);
        chk("sh_lat",  32'(lat), 32'd4);
        chk("sh_mem5", mem_arr[5], 32'hA500_8001);
        do_req(1'b0, 2'd1, 1'b0, 32'h16, 32'h0, lat, rd, err, wrc, wa);
        chk("lh_16", rd, 32'hFFFF_8001);
        do_req(1'b0, 2'd1, 1'b1, 32'h14, 32'h0, lat, rd, err, wrc, wa);
        chk("lhu_14", rd, 32'h0000_A500);

        do_req(1'b1, 2'd3, 1'b0, 32'h10, 32'h5555_5555, lat, rd, err, wrc, wa);
        chk("ill_lat",    32'(lat), 32'd1);
        chk("ill_err",    32'(err), 32'd1);
        chk("ill_wr_cnt", 32'(wrc), 32'd0);
        chk("ill_mem4",   mem_arr[4], 32'h1122_AA44);

`ifdef LSU_ALIGN_CHECK_EN
        do_req(1'b0, 2'd2, 1'b0, 32'h11, 32'h0, lat, rd, err, wrc, wa);
        chk("lw_mis_lat",   32'(lat), 32'd1);
        chk("lw_mis_err",   32'(err), 32'd1);
        chk("lw_mis_rdata", rd,       32'd0);
        do_req(1'b1, 2'd2, 1'b0, 32'h1D, 32'h9999_9999, lat, rd, err, wrc, wa);
        chk("sw_mis_err",   32'(err), 32'd1);
        chk("sw_mis_wrc",   32'(wrc), 32'd0);
        chk("sw_mis_mem7",  mem_arr[7], init_val(7));
`else
        do_req(1'b0, 2'd2, 1'b0, 32'h11, 32'h0, lat, rd, err, wrc, wa);
        chk("lw_mis_lat",   32'(lat), 32'd3);
        chk("lw_mis_err",   32'(err), 32'd0);
        chk("lw_mis_rdata", rd,       32'h1122_AA44);
        do_req(1'b0, 2'd1, 1'b0, 32'h13, 32'h0, lat, rd, err, wrc, wa);
        chk("lh_mis_rdata", rd,       32'hFFFF_AA44);
`endif

        bd_write(8'd6, 32'h0102_0304);
        drive_req(1'b1, 2'd0, 1'b0, 32'h18, 32'h0000_0077);
        found = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (!mem_bus.mem_to_reg) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("rst_mid_found_write", 32'(found), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_mtr_immediate", 32'(mem_bus.mem_to_reg), 32'd1);
        cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (lsu_bus.resp_valid || !mem_bus.mem_to_reg) cnt++;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (lsu_bus.resp_valid) cnt++;
        end
        chk("rst_mid_no_resp",  32'(cnt), 32'd0);
        chk("rst_mid_mem6",     mem_arr[6], 32'h0102_0304);
        chk("rst_mid_ready",    32'(lsu_bus.req_ready), 32'd1);

        do_req(1'b0, 2'd2, 1'b0, 32'h18, 32'h0, lat, rd, err, wrc, wa);
        chk("post_rst_lw", rd, 32'h0102_0304);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mips_lsu.md
Name: mips_lsu

Overview:
Load/store unit: the initiator on the data-memory port of the MIPS datapath. It accepts byte/half/word load and store requests from the pipeline and converts byte addresses to word indices. It drives the word-wide synchronous data memory (address, write_data, mem_to_reg; read_data registered, 1-cycle latency), performs read-modify-write for sub-word stores, and returns sign/zero-extended load data. Byte order is big-endian: byte 0 is bits [31:24].

Parameters:
DATA_W, 32, data and address width
MEM_IDX_W, 8, word-index bits used by the data memory (256 words)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  unit idle, can accept request
req_we  in  1  1=store, 0=load
req_size  in  2  0=byte, 1=half, 2=word, 3=illegal
req_unsigned  in  1  loads only: 1=zero-extend, 0=sign-extend
req_addr  in  32  byte address
req_wdata  in  32  store data, right-justified for byte/half
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  extended load data; 0 for stores/errors
resp_err  out  1  request rejected, no memory access
address  out  32  word index to memory = {2'b0, byte_addr[31:2]}
write_data  out  32  word to write
mem_to_reg  out  1  1=read (safe idle), 0=write this cycle
read_data  in  32  memory read word, valid the cycle after a read is driven

Behaviour:
- Reset: state IDLE; req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, address=0, write_data=0, mem_to_reg=1.
- The memory writes on every edge with mem_to_reg=0. mem_to_reg is decoded from the state register only: 0 solely in state WRITE, 1 in all other states. Never glitch it low.
- States: IDLE, READ, MERGE, WRITE, DONE. req_ready = (state==IDLE). Accept on req_valid&&req_ready at cycle T, registering all req_* fields.
- LW/LB/LH: IDLE -> READ (T+1, drive address) -> MERGE (T+2, capture read_data, extract and extend) -> DONE (T+3: resp_valid=1, resp_rdata valid) -> IDLE.
- SW: IDLE -> WRITE (T+1, write_data=req_wdata) -> DONE (T+2) -> IDLE.
- SB/SH: IDLE -> READ (T+1) -> MERGE (T+2, replace the addressed lane of read_data with the low byte/half of wdata) -> WRITE (T+3) -> DONE (T+4) -> IDLE.
- Lane select: byte lane = addr[1:0], lane 0 = bits [31:24]. Half lane = addr[1], 0 = bits [31:16].
- req_size==3: no memory access; IDLE -> DONE with resp_err=1 at T+1.
- resp_valid is a single-cycle pulse with no back-pressure. A new request is accepted the cycle after DONE (IDLE again).
- req_valid while busy is ignored; the requester must hold it until req_ready.
- Address bits above MEM_IDX_W+1 are passed through; the memory ignores them.
- Async reset mid-operation: immediate return to IDLE and mem_to_reg=1. A pending WRITE is suppressed and the response is dropped.

Optional Feature:
LSU_ALIGN_CHECK_EN.
- Defined: a half access with addr[0]!=0, or a word access with addr[1:0]!=0, takes no memory access; DONE at T+1 with resp_err=1, resp_rdata=0.
- Undefined: misalignment is not checked. Low address bits are forced to the natural alignment (half: addr[0]=0; word: addr[1:0]=0) and the access proceeds normally.

Decomposition:
- Package mips_lsu_pkg: size encodings (SZ_BYTE/SZ_HALF/SZ_WORD), state enum, lane constants.
- Sub-module mips_lsu_lane: purely combinational. Extracts and extends load data, and merges sub-word store data, from (word, addr[1:0], size, unsigned, wdata). It is shared by the MERGE state logic.

Test Plan:
- After reset: mem_to_reg=1, req_ready=1, resp_valid=0; idle for 20 cycles -> memory contents unchanged.
- SW addr 0x10, data 0xDEADBEEF -> address=4, mem_to_reg=0 for exactly 1 cycle; resp_valid at T+2. Then LW 0x10 -> resp_rdata 0xDEADBEEF at T+3.
- Word 4 = 0x11223344; SB addr 0x12, wdata 0xAA -> word 4 = 0x1122AA44, resp_valid at T+4. LB 0x12 -> 0xFFFFFFAA; LBU 0x12 -> 0x000000AA.
- LH 0x12 -> 0xFFFFAA44 (sign bit from 0xAA). LHU 0x10 -> 0x00001122.
- req_size=3 -> resp_err=1 at T+1, mem_to_reg stays 1. With LSU_ALIGN_CHECK_EN: LW 0x11 -> resp_err=1 and no write. Without it, LW 0x11 reads word 4.
- Assert rst_n low during the WRITE cycle of an SB -> mem_to_reg=1 immediately, memory word unchanged, no resp_valid, req_ready=1 after release.
